regs_file_mp: RTL and testbench

Parametrised multi-read-port integer register file for the pipelined CPU. It replaces the single-cycle two-port file and adds:

- a write-to-read bypass;
- a per-register busy scoreboard for hazard detection;
- a sequenced bulk clear that runs without asserting reset.

It sits between decode (reads, issue) and writeback (writes).

---
 rtl/regs_file_pkg.sv | 18 +
 rtl/regs_file_mp_if.sv | 32 +++
 rtl/regs_scoreboard.sv | 58 +++++
 rtl/regs_file_mp.sv | 105 ++++++++++
 tb/tb_regs_file_mp.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regs_file_pkg.sv
// Shared types and helpers for the multi-read-port register file and its scoreboard.
package regs_file_pkg;

  // Bulk-clear sequencer states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Hard-wired zero register number.
  localparam int X0 = 0;

  // Register-number width for a given register count.
  function automatic int aw_of(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regs_file_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback, issue and bulk clear.
interface regs_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  import regs_file_pkg::*;

  localparam int AW = aw_of(NREGS);

  logic [NREAD*AW-1:0]   rd_num;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_num;
  logic [XLEN-1:0]       wr_data;
  logic                  issue_en;
  logic [AW-1:0]         issue_num;
  logic                  clr_req;
  logic                  clr_busy;

  modport slave (
    input  rd_num, wr_en, wr_num, wr_data, issue_en, issue_num, clr_req,
    output rd_data, rd_busy, clr_busy
  );

  modport master (
    output rd_num, wr_en, wr_num, wr_data, issue_en, issue_num, clr_req,
    input  rd_data, rd_busy, clr_busy
  );

endinterface

// File: rtl/regs_scoreboard.sv
// Per-register busy bits with set (issue), clear (writeback) and sequenced wipe inputs,
// plus a raw busy lookup for every read port.
module regs_scoreboard
  import regs_file_pkg::*;
#(
  parameter int  NREGS = 32,
  parameter int  NREAD = 2,
  localparam int AW    = aw_of(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [AW-1:0]       set_num,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_num,
  input  logic                wipe_en,
  input  logic [AW-1:0]       wipe_num,
  input  logic [NREAD*AW-1:0] lk_num,
  output logic [NREAD-1:0]    lk_busy
);

  logic busy_reg [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == X0) begin : g_zero
        assign busy_reg[gi] = 1'b0;
      end else begin : g_live
        logic set_hit;
        logic clr_hit;
        logic wipe_hit;

        assign set_hit  = set_en  && (set_num  == AW'(gi));
        assign clr_hit  = clr_en  && (clr_num  == AW'(gi));
        assign wipe_hit = wipe_en && (wipe_num == AW'(gi));

        // A new producer issued in the same cycle as a writeback keeps the register busy.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            busy_reg[gi] <= 1'b0;
          end else if (set_hit) begin
            busy_reg[gi] <= 1'b1;
          end else if (clr_hit || wipe_hit) begin
            busy_reg[gi] <= 1'b0;
          end
        end
      end
    end

    for (gi = 0; gi < NREAD; gi++) begin : g_lookup
      logic [AW-1:0] num;
      assign num         = lk_num[gi*AW +: AW];
      assign lk_busy[gi] = (num != AW'(X0)) && busy_reg[num];
    end
  endgenerate

endmodule

// File: rtl/regs_file_mp.sv
// Multi-read-port integer register file with optional write-to-read bypass, busy
// scoreboard and a sequenced bulk clear that zeroes x1..x(NREGS-1) one per cycle.
module regs_file_mp
  import regs_file_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           reset,
  regs_file_mp_if.slave bus
);

  localparam int            AW       = aw_of(NREGS);
  localparam logic [AW-1:0] X0_NUM   = AW'(X0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [0:0]    ST_IDLE  = IDLE;
  localparam logic [0:0]    ST_CLEAR = CLEAR;

  logic [0:0]      state_reg;
  logic [AW-1:0]   idx_reg;
  logic [XLEN-1:0] regs [NREGS];
  logic            clearing;
  logic            wr_act;
  logic            iss_act;
  logic [NREAD-1:0] sb_busy;

  // Writeback and issue are locked out for the whole clear sequence.
  assign clearing = (state_reg == ST_CLEAR);
  assign wr_act   = !clearing && bus.wr_en    && (bus.wr_num    != X0_NUM);
  assign iss_act  = !clearing && bus.issue_en && (bus.issue_num != X0_NUM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= AW'(1);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_reg <= ST_CLEAR;
            idx_reg   <= AW'(1);
          end
        end
        ST_CLEAR: begin
          idx_reg <= idx_reg + AW'(1);
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (clearing) begin
      regs[idx_reg] <= '0;
    end else if (wr_act) begin
      regs[bus.wr_num] <= bus.wr_data;
    end
  end

  regs_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_act),
    .set_num  (bus.issue_num),
    .clr_en   (wr_act),
    .clr_num  (bus.wr_num),
    .wipe_en  (clearing),
    .wipe_num (idx_reg),
    .lk_num   (bus.rd_num),
    .lk_busy  (sb_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] num;
      logic          fwd;

      assign num = bus.rd_num[gi*AW +: AW];
      // wr_act already excludes x0 and the clear sequence, so forwarding never hits either.
      assign fwd = (BYPASS != 0) && wr_act && (bus.wr_num == num);

      assign bus.rd_data[gi*XLEN +: XLEN] = (num == X0_NUM) ? '0 :
                                            fwd             ? bus.wr_data :
                                                              regs[num];
      assign bus.rd_busy[gi] = sb_busy[gi] && !fwd;
    end
  endgenerate

  assign bus.clr_busy = clearing;

endmodule

// File: tb/tb_regs_file_mp.sv
// Scoreboard bench: drives a BYPASS=1 and a BYPASS=0 register file with identical stimulus
// and checks every read port, busy flag and clr_busy against a behavioural model.
module tb_regs_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic clk;
  logic reset;
  logic [NREAD*AW-1:0] rd_num;
  logic                wr_en;
  logic [AW-1:0]       wr_num;
  logic [XLEN-1:0]     wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_num;
  logic                clr_req;

  regs_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_bp ();
  regs_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_nb ();

  assign bus_bp.rd_num    = rd_num;
  assign bus_bp.wr_en     = wr_en;
  assign bus_bp.wr_num    = wr_num;
  assign bus_bp.wr_data   = wr_data;
  assign bus_bp.issue_en  = issue_en;
  assign bus_bp.issue_num = issue_num;
  assign bus_bp.clr_req   = clr_req;
  assign bus_nb.rd_num    = rd_num;
  assign bus_nb.wr_en     = wr_en;
  assign bus_nb.wr_num    = wr_num;
  assign bus_nb.wr_data   = wr_data;
  assign bus_nb.issue_en  = issue_en;
  assign bus_nb.issue_num = issue_num;
  assign bus_nb.clr_req   = clr_req;

  regs_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_bp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_bp.slave)
  );

  regs_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = rd_data, 1 = rd_busy, 2 = clr_busy; dut: 0 = bypass, 1 = no bypass
  typedef struct {
    int          kind;
    int          dut;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_run;
  int   n_fail;

  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];
  bit          m_clear;
  int          m_idx;

  task automatic model_zero();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_clear = 1'b0;
    m_idx   = 1;
  endtask

  task automatic model_edge();
    if (!reset) return;
    if (m_clear) begin
      m_regs[m_idx] = '0;
      m_busy[m_idx] = 1'b0;
      if (m_idx == NREGS - 1) m_clear = 1'b0;
      m_idx++;
    end else begin
      if (wr_en && wr_num != 0) begin
        m_regs[wr_num] = wr_data;
        m_busy[wr_num] = 1'b0;
      end
      if (issue_en && issue_num != 0) m_busy[issue_num] = 1'b1;
      if (clr_req) begin
        m_clear = 1'b1;
        m_idx   = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_num = '0; wr_data = '0;
    issue_en = 1'b0; issue_num = '0; clr_req = 1'b0;
  endtask

  task automatic set_rd(input int a, input int b);
    rd_num = {AW'(b), AW'(a)};
  endtask

  task automatic push_exp();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NREAD; p++) begin
        int          n;
        bit          fwd;
        logic [31:0] dv;
        logic        bv;
        n   = int'(rd_num[p*AW +: AW]);
        fwd = (d == 0) && !m_clear && wr_en && (wr_num != 0) && (int'(wr_num) == n);
        if (n == 0) begin
          dv = '0; bv = 1'b0;
        end else if (fwd) begin
          dv = wr_data; bv = 1'b0;
        end else begin
          dv = m_regs[n]; bv = m_busy[n];
        end
        sbq.push_back('{0, d, p, dv});
        sbq.push_back('{1, d, p, {31'b0, bv}});
      end
      sbq.push_back('{2, d, 0, {31'b0, m_clear}});
    end
  endtask

  function automatic logic [31:0] get_obs(input int kind, input int d, input int p);
    logic [31:0] v;
    v = '0;
    if (d == 0) begin
      case (kind)
        0:       v = bus_bp.rd_data[p*XLEN +: XLEN];
        1:       v = {31'b0, bus_bp.rd_busy[p]};
        default: v = {31'b0, bus_bp.clr_busy};
      endcase
    end else begin
      case (kind)
        0:       v = bus_nb.rd_data[p*XLEN +: XLEN];
        1:       v = {31'b0, bus_nb.rd_busy[p]};
        default: v = {31'b0, bus_nb.clr_busy};
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    exp_t        e;
    logic [31:0] obs;
    reset = 1'b0;
    idle_inputs();
    set_rd(5, 31);
    model_zero();
    repeat (3) tick();
    reset = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      set_rd(r, NREGS - 1 - r);
      push_exp();
      @(negedge clk);
      $display("[TB] reset: read x%0d / x%0d", r, NREGS - 1 - r);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL reset kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    exp_t        e;
    logic [31:0] obs;
    for (int s = 0; s < 2; s++) begin
      idle_inputs();
      set_rd(5, 5);
      if (s == 0) begin
        wr_en = 1'b1; wr_num = 5; wr_data = 32'hDEADBEEF;
      end
      push_exp();
      @(negedge clk);
      $display("[TB] write_read: step %0d wr_en=%0b x5", s, wr_en);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL write_read kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    exp_t        e;
    logic [31:0] obs;
    for (int s = 0; s < 2; s++) begin
      idle_inputs();
      if (s == 0) begin
        set_rd(7, 5);
        wr_en = 1'b1; wr_num = 7; wr_data = 32'h00001234;
      end else begin
        set_rd(7, 7);
      end
      push_exp();
      @(negedge clk);
      $display("[TB] bypass: step %0d x7", s);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL bypass kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_x0();
    exp_t        e;
    logic [31:0] obs;
    for (int s = 0; s < 2; s++) begin
      idle_inputs();
      set_rd(0, 0);
      if (s == 0) begin
        wr_en = 1'b1; wr_num = 0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_num = 0;
      end
      push_exp();
      @(negedge clk);
      $display("[TB] x0: step %0d write+issue x0", s);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL x0 kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_scoreboard();
    exp_t        e;
    logic [31:0] obs;
    for (int s = 0; s < 6; s++) begin
      idle_inputs();
      set_rd(3, 3);
      case (s)
        0: begin issue_en = 1'b1; issue_num = 3; end
        2: begin wr_en = 1'b1; wr_num = 3; wr_data = 32'h0000CAFE; end
        4: begin
          issue_en = 1'b1; issue_num = 3;
          wr_en = 1'b1; wr_num = 3; wr_data = 32'h0000AAAA;
        end
        default: ;
      endcase
      push_exp();
      @(negedge clk);
      $display("[TB] scoreboard: step %0d issue=%0b wr=%0b x3", s, issue_en, wr_en);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL scoreboard kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] obs;
    for (int s = 1; s < NREGS + 2; s++) begin
      idle_inputs();
      if (s < NREGS) begin
        wr_en = 1'b1; wr_num = AW'(s); wr_data = 32'h00000011;
        set_rd(s, s - 1);
      end else if (s == NREGS) begin
        issue_en = 1'b1; issue_num = 9;
        set_rd(9, 8);
      end else begin
        set_rd(9, 31);
      end
      push_exp();
      @(negedge clk);
      $display("[TB] back_to_back: step %0d", s);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL back_to_back kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_clear();
    exp_t        e;
    logic [31:0] obs;
    int          busy_cycles;
    busy_cycles = 0;
    // step -1: clear request with a simultaneous write; 0..39 clear window; 40..71 read-all
    for (int s = -1; s < 40 + NREGS; s++) begin
      idle_inputs();
      set_rd(2, 9);
      if (s == -1) begin
        clr_req = 1'b1;
        wr_en = 1'b1; wr_num = 2; wr_data = 32'h00000022;
      end else if (s == 4) begin
        wr_en = 1'b1; wr_num = 4; wr_data = 32'h00000055;
        issue_en = 1'b1; issue_num = 4;
        set_rd(4, 9);
      end else if (s >= 40) begin
        set_rd(s - 40, NREGS - 1 - (s - 40));
      end
      push_exp();
      @(negedge clk);
      if (s >= 0 && s < 40 && bus_bp.clr_busy === 1'b1) busy_cycles++;
      $display("[TB] clear: step %0d clr_busy=%0b", s, bus_bp.clr_busy);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL clear kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      tick();
    end
    n_run++;
    if (busy_cycles !== NREGS - 1) begin
      n_fail++;
      $display("FAIL clear_length got=%0d cycles want=%0d", busy_cycles, NREGS - 1);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t        e;
    logic [31:0] obs;
    idle_inputs();
    wr_en = 1'b1; wr_num = 6; wr_data = 32'h00000066;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    idle_inputs();
    repeat (10) tick();
    // reset lands mid-cycle; everything must drop without waiting for an edge
    #3;
    reset = 1'b0;
    model_zero();
    for (int s = 0; s < NREGS + 1; s++) begin
      if (s == 0) begin
        set_rd(6, 31);
        #1;
      end else begin
        set_rd(s - 1, NREGS - s);
        if (s == 1) begin
          tick();
          reset = 1'b1;
        end
      end
      push_exp();
      if (s != 0) @(negedge clk);
      $display("[TB] reset_mid_clear: step %0d reset=%0b", s, reset);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        obs = get_obs(e.kind, e.dut, e.port);
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL reset_mid_clear kind=%0d dut=%0d port=%0d got=%h want=%h", e.kind, e.dut, e.port, obs, e.val);
        end
      end
      if (s != 0) tick();
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
